// File: rtl/starfield_pkg.sv
// Shared constants for the parallax starfield: LFSR tap table, per-layer seeds
// and power-on scroll speeds.
package starfield_pkg;

    localparam int MAX_LEN    = 24;
    localparam int MAX_LAYERS = 4;

    typedef logic [MAX_LEN-1:0] lfsr_word_t;
    typedef logic signed [3:0]  speed_t;

    // Nonzero for every supported LEN so no layer can start in the lockup state.
    localparam lfsr_word_t SEED [MAX_LAYERS] = '{
        24'h1FFFFF, 24'h0F1E3C, 24'h15A5A5, 24'h0C3C3C
    };

    localparam speed_t DEF_SPEED [MAX_LAYERS] = '{
        -4'sd1, -4'sd2, -4'sd3, -4'sd4
    };

    // Maximal-length Fibonacci taps, bit k set means stage k+1 feeds the XOR.
    function automatic lfsr_word_t TAPS_BY_LEN(input int len);
        lfsr_word_t taps;
        case (len)
            16:      taps = 24'h00D008;
            17:      taps = 24'h012000;
            18:      taps = 24'h020400;
            19:      taps = 24'h040023;
            20:      taps = 24'h090000;
            21:      taps = 24'h140000;
            22:      taps = 24'h300000;
            23:      taps = 24'h420000;
            24:      taps = 24'hE10000;
            default: taps = 24'h140000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/starfield_lfsr_layer.sv
// One star layer: frame counter with drift-adjusted period, double-buffered
// speed, seeded Fibonacci LFSR and the density/brightness taps.
module starfield_lfsr_layer
    import starfield_pkg::*;
#(
    parameter int                H         = 800,
    parameter int                V         = 525,
    parameter int                LEN       = 21,
    parameter int                MASK_BITS = 12,
    parameter int                BRIGHT_W  = 8,
    parameter int                SHIFT     = 0,
    parameter logic [LEN-1:0]    SEED_VAL  = '1,
    parameter logic [LEN-1:0]    TAPS_VAL  = '1,
    parameter logic signed [3:0] DEF_SPD   = -4'sd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_we,
    input  logic signed [3:0]   i_speed,
    output logic                o_wrap,
    output logic                o_hit,
    output logic [BRIGHT_W-1:0] o_bright
);

    localparam int HV = H * V;
    localparam int CW = $clog2(HV + 8);
    localparam logic signed [CW:0]  HV_M1    = (CW+1)'(HV - 1);
    localparam logic [LEN-1:0]      LOW_MASK = LEN'((64'(1) << MASK_BITS) - 64'(1));

    logic [CW-1:0]      r_cnt;
    logic [LEN-1:0]     r_sreg;
    logic signed [3:0]  r_speed;
    logic signed [3:0]  r_shadow;

    logic signed [CW:0] w_speed_ext;
    logic signed [CW:0] w_limit;
    logic               w_wrap;
    logic               w_fb;
    logic [LEN-1:0]     w_sreg_adv;

    // Last pixel index of this frame is H*V + speed - 1; one extra bit keeps
    // the sum non-negative for the most negative speed.
    assign w_speed_ext = {{(CW-3){r_speed[3]}}, r_speed};
    assign w_limit     = HV_M1 + w_speed_ext;
    assign w_wrap      = ($signed({1'b0, r_cnt}) == w_limit);

    assign w_fb        = ^(r_sreg & TAPS_VAL);
    assign w_sreg_adv  = {r_sreg[LEN-2:0], w_fb};

    // The LFSR holds the seed whenever the counter sits at 0, so every frame
    // replays the same sequence and a shorter/longer period shifts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_sreg   <= SEED_VAL;
            r_speed  <= DEF_SPD;
            r_shadow <= DEF_SPD;
        end else begin
            if (i_we) begin
                r_shadow <= i_speed;
            end
            if (i_en) begin
                if (w_wrap) begin
                    r_cnt   <= '0;
                    r_sreg  <= SEED_VAL;
                    r_speed <= r_shadow;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_sreg  <= w_sreg_adv;
                end
            end
        end
    end

    assign o_wrap   = w_wrap;
    assign o_hit    = &(r_sreg | LOW_MASK);
    assign o_bright = r_sreg[BRIGHT_W-1:0] >> SHIFT;

endmodule

// File: rtl/starfield_parallax.sv
// Multi-layer starfield: per-layer LFSR generators, fixed-priority combine
// (layer 0 nearest) and registered pixel outputs.
module starfield_parallax
    import starfield_pkg::*;
#(
    parameter int H        = 800,
    parameter int V        = 525,
    parameter int LAYERS   = 3,
    parameter int LEN      = 21,
    parameter int MASK_W   = 12,
    parameter int BRIGHT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_layer,
    input  logic signed [3:0]   cfg_speed,
    output logic                sf_on,
    output logic [BRIGHT_W-1:0] sf_star,
    output logic [1:0]          sf_layer,
    output logic                frame_wrap
);

    if (H * V - 8 <= 0) begin : g_bad_frame
        $error("starfield_parallax: H*V must exceed 8");
    end
    if (LAYERS < 1 || LAYERS > MAX_LAYERS) begin : g_bad_layers
        $error("starfield_parallax: LAYERS must be 1..4");
    end
    if (LEN < 16 || LEN > MAX_LEN) begin : g_bad_len
        $error("starfield_parallax: LEN must be 16..24");
    end
    if (BRIGHT_W > LEN || MASK_W + LAYERS - 1 > LEN) begin : g_bad_widths
        $error("starfield_parallax: BRIGHT_W and deepest mask must fit in LEN");
    end

    logic [LAYERS-1:0]   w_we;
    logic [LAYERS-1:0]   w_wrap;
    logic [LAYERS-1:0]   w_hit;
    logic [BRIGHT_W-1:0] w_bright [LAYERS];
    logic                w_wrap_unused;

    logic                w_any;
    logic [BRIGHT_W-1:0] w_win_bright;
    logic [1:0]          w_win_layer;

    logic                r_sf_on;
    logic [BRIGHT_W-1:0] r_sf_star;
    logic [1:0]          r_sf_layer;
    logic                r_frame_wrap;

    // A cfg_layer beyond the last layer matches no decode term and is dropped.
    for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
        assign w_we[gi] = cfg_we && (cfg_layer == 2'(gi));

        starfield_lfsr_layer #(
            .H         (H),
            .V         (V),
            .LEN       (LEN),
            .MASK_BITS (MASK_W + gi),
            .BRIGHT_W  (BRIGHT_W),
            .SHIFT     (gi),
            .SEED_VAL  (LEN'(SEED[gi])),
            .TAPS_VAL  (LEN'(TAPS_BY_LEN(LEN))),
            .DEF_SPD   (DEF_SPEED[gi])
        ) u_layer (
            .clk      (clk),
            .rst      (rst),
            .i_en     (en),
            .i_we     (w_we[gi]),
            .i_speed  (cfg_speed),
            .o_wrap   (w_wrap[gi]),
            .o_hit    (w_hit[gi]),
            .o_bright (w_bright[gi])
        );
    end

    // Only layer 0 defines the frame pulse; the other wraps stay internal.
    assign w_wrap_unused = ^w_wrap;

    // Walk from the deepest layer up so the nearest hitting layer wins.
    always_comb begin
        w_any        = 1'b0;
        w_win_bright = '0;
        w_win_layer  = '0;
        for (int li = LAYERS - 1; li >= 0; li--) begin
            if (w_hit[li]) begin
                w_any        = 1'b1;
                w_win_bright = w_bright[li];
                w_win_layer  = 2'(li);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sf_on      <= 1'b0;
            r_sf_star    <= '0;
            r_sf_layer   <= '0;
            r_frame_wrap <= 1'b0;
        end else begin
            r_frame_wrap <= en && w_wrap[0];
            if (en) begin
                r_sf_on    <= w_any;
                r_sf_star  <= w_win_bright;
                r_sf_layer <= w_win_layer;
            end
        end
    end

    assign sf_on      = r_sf_on;
    assign sf_star    = r_sf_star;
    assign sf_layer   = r_sf_layer;
    assign frame_wrap = r_frame_wrap;

endmodule
